// File: rtl/header_inserter.sv
// rtl/header_inserter.sv - prepends a registered fixed-size header to each Avalon-ST packet.
// Optional statistics outputs (pkt_count, hdr_stall) are enabled by HEADER_INSERTER_STATS_EN.
module header_inserter #(
    parameter int DATA_WIDTH  = 128,
    parameter int HEADER_SIZE = 256
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [HEADER_SIZE-1:0]          header_data,
    input  logic                            header_valid,
    output logic                            header_ready,
    input  logic [DATA_WIDTH-1:0]           data_in_data,
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    input  logic                            data_in_sop,
    input  logic                            data_in_eop,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] data_in_empty,
    output logic [DATA_WIDTH-1:0]           data_out_data,
    output logic                            data_out_valid,
    input  logic                            data_out_ready,
    output logic                            data_out_sop,
    output logic                            data_out_eop,
`ifdef HEADER_INSERTER_STATS_EN
    output logic [31:0]                     pkt_count,
    output logic                            hdr_stall,
`endif
    output logic [$clog2(DATA_WIDTH/8)-1:0] data_out_empty
);

    localparam int HEADER_WORDS = HEADER_SIZE / DATA_WIDTH;
    localparam int CNT_W        = $clog2(HEADER_WORDS) + 1;

    generate
        if ((HEADER_SIZE % DATA_WIDTH) != 0 || HEADER_SIZE < DATA_WIDTH) begin : g_bad_params
            $error("header_inserter: HEADER_SIZE must be a non-zero multiple of DATA_WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t                   state;
    state_t                   next_state;
    logic [HEADER_SIZE-1:0]   hdr_reg;
    logic [CNT_W-1:0]         cnt;
    logic [DATA_WIDTH-1:0]    hdr_word;
    logic                     last_word;

    // Start-of-packet is regenerated here, so the upstream marker carries no information.
    logic unused_in_sop;
    assign unused_in_sop = data_in_sop;

    always_comb begin
        hdr_word = '0;
        for (int i = 0; i < HEADER_WORDS; i++) begin
            if (cnt == CNT_W'(i)) begin
                hdr_word = hdr_reg[HEADER_SIZE-1-i*DATA_WIDTH -: DATA_WIDTH];
            end
        end
    end

    assign last_word = (cnt == CNT_W'(HEADER_WORDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state     = state;
        header_ready   = 1'b0;
        data_in_ready  = 1'b0;
        data_out_valid = 1'b0;
        data_out_data  = '0;
        data_out_sop   = 1'b0;
        data_out_eop   = 1'b0;
        data_out_empty = '0;
        case (state)
            IDLE: begin
                header_ready = 1'b1;
                if (header_valid) begin
                    next_state = HEADER;
                end
            end
            HEADER: begin
                data_out_valid = 1'b1;
                data_out_data  = hdr_word;
                data_out_sop   = (cnt == '0);
                if (data_out_ready && last_word) begin
                    next_state = DATA;
                end
            end
            DATA: begin
                data_out_valid = data_in_valid;
                data_in_ready  = data_out_ready;
                data_out_data  = data_in_data;
                data_out_eop   = data_in_eop;
                data_out_empty = data_in_empty;
                if (data_in_valid && data_out_ready && data_in_eop) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // The header register only loads on accept, so header words stay stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_reg <= '0;
            cnt     <= '0;
        end else if (state == IDLE && header_valid) begin
            hdr_reg <= header_data;
            cnt     <= '0;
        end else if (state == HEADER && data_out_ready) begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef HEADER_INSERTER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_count <= '0;
        end else if (data_out_valid && data_out_ready && data_out_eop) begin
            pkt_count <= pkt_count + 32'd1;
        end
    end

    assign hdr_stall = (state == DATA) && header_valid;
`endif

endmodule

// File: tb/tb_header_inserter.sv
// tb/tb_header_inserter.sv - directed self-checking bench for header_inserter.
module tb_header_inserter;

    localparam int DW  = 128;
    localparam int HS  = 256;
    localparam int EW  = 4;
    localparam int DW2 = 64;
    localparam int EW2 = 3;
    localparam int OW  = 2 + 3 + EW + DW;

    typedef struct packed {
        logic          hv;
        logic [HS-1:0] hd;
        logic          iv;
        logic [DW-1:0] id;
        logic          ie;
        logic [EW-1:0] iemp;
        logic          ordy;
    } stim_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [HS-1:0] header_data;
    logic          header_valid, header_ready;
    logic [DW-1:0] in_data, out_data;
    logic          in_valid, in_ready, in_sop, in_eop;
    logic [EW-1:0] in_empty, out_empty;
    logic          out_valid, out_ready, out_sop, out_eop;

    logic [DW2-1:0] s_header_data;
    logic           s_header_valid, s_header_ready;
    logic [DW2-1:0] s_in_data, s_out_data;
    logic           s_in_valid, s_in_ready, s_in_sop, s_in_eop;
    logic [EW2-1:0] s_in_empty, s_out_empty;
    logic           s_out_valid, s_out_ready, s_out_sop, s_out_eop;

`ifdef HEADER_INSERTER_STATS_EN
    logic [31:0] pkt_count, s_pkt_count;
    logic        hdr_stall, s_hdr_stall;
`endif

    header_inserter #(.DATA_WIDTH(DW), .HEADER_SIZE(HS)) u_dut (
        .clk(clk), .rst(rst),
        .header_data(header_data), .header_valid(header_valid), .header_ready(header_ready),
        .data_in_data(in_data), .data_in_valid(in_valid), .data_in_ready(in_ready),
        .data_in_sop(in_sop), .data_in_eop(in_eop), .data_in_empty(in_empty),
        .data_out_data(out_data), .data_out_valid(out_valid), .data_out_ready(out_ready),
        .data_out_sop(out_sop), .data_out_eop(out_eop),
`ifdef HEADER_INSERTER_STATS_EN
        .pkt_count(pkt_count), .hdr_stall(hdr_stall),
`endif
        .data_out_empty(out_empty)
    );

    header_inserter #(.DATA_WIDTH(DW2), .HEADER_SIZE(DW2)) u_dut_single (
        .clk(clk), .rst(rst),
        .header_data(s_header_data), .header_valid(s_header_valid), .header_ready(s_header_ready),
        .data_in_data(s_in_data), .data_in_valid(s_in_valid), .data_in_ready(s_in_ready),
        .data_in_sop(s_in_sop), .data_in_eop(s_in_eop), .data_in_empty(s_in_empty),
        .data_out_data(s_out_data), .data_out_valid(s_out_valid), .data_out_ready(s_out_ready),
        .data_out_sop(s_out_sop), .data_out_eop(s_out_eop),
`ifdef HEADER_INSERTER_STATS_EN
        .pkt_count(s_pkt_count), .hdr_stall(s_hdr_stall),
`endif
        .data_out_empty(s_out_empty)
    );

    int total  = 0;
    int passed = 0;

    localparam logic [DW-1:0] HA = {8{16'hAAAA}};
    localparam logic [DW-1:0] HB = {8{16'hBBBB}};
    localparam logic [DW-1:0] HC = {8{16'hCCCC}};
    localparam logic [DW-1:0] HD = {8{16'hDDDD}};
    localparam logic [DW-1:0] HE = {8{16'hEEEE}};
    localparam logic [DW-1:0] HF = {8{16'hFFFF}};
    localparam logic [DW-1:0] H1 = {8{16'h1111}};
    localparam logic [DW-1:0] H2 = {8{16'h2222}};
    localparam logic [DW-1:0] D0 = 128'hD0D0_0000_0000_0000_0000_0000_0000_00D0;
    localparam logic [DW-1:0] D1 = 128'hD1D1_0000_0000_0000_0000_0000_0000_00D1;
    localparam logic [DW-1:0] D2 = 128'hD2D2_0000_0000_0000_0000_0000_0000_00D2;
    localparam logic [DW-1:0] D3 = 128'hD3D3_0000_0000_0000_0000_0000_0000_00D3;

    // Data is only meaningful while valid, so it is zeroed otherwise before comparing.
    function automatic logic [OW-1:0] obs();
        return {header_ready, in_ready, out_valid, out_sop, out_eop, out_empty,
                out_valid ? out_data : {DW{1'b0}}};
    endfunction

    function automatic logic [71:0] obs_single();
        return {s_header_ready, s_in_ready, s_out_valid, s_out_sop, s_out_eop, s_out_empty,
                s_out_valid ? s_out_data : {DW2{1'b0}}};
    endfunction

    function automatic logic [OW-1:0] mk(input logic hr, input logic ir, input logic v,
                                         input logic s, input logic e,
                                         input logic [EW-1:0] emp, input logic [DW-1:0] d);
        return {hr, ir, v, s, e, emp, d};
    endfunction

    function automatic stim_t sv(input logic hv, input logic [HS-1:0] hd, input logic iv,
                                 input logic [DW-1:0] id, input logic ie,
                                 input logic [EW-1:0] iemp, input logic ordy);
        stim_t r;
        r.hv = hv; r.hd = hd; r.iv = iv; r.id = id; r.ie = ie; r.iemp = iemp; r.ordy = ordy;
        return r;
    endfunction

    // Upstream sop is asserted on every valid beat to show that the DUT ignores it.
    task automatic apply(input stim_t s);
        header_valid = s.hv;
        header_data  = s.hd;
        in_valid     = s.iv;
        in_data      = s.id;
        in_sop       = s.iv;
        in_eop       = s.ie;
        in_empty     = s.iemp;
        out_ready    = s.ordy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(sv(0, '0, 0, '0, 0, '0, 1));
        s_header_valid = 0; s_header_data = '0; s_in_valid = 0; s_in_data = '0;
        s_in_sop = 0; s_in_eop = 0; s_in_empty = '0; s_out_ready = 1;
        @(negedge clk);
        total++;
        if (obs() !== mk(1, 0, 0, 0, 0, 0, '0))
            $display("FAIL reset_outputs: got %h, expected %h", obs(), mk(1, 0, 0, 0, 0, 0, '0));
        else passed++;
        total++;
        if (obs_single() !== {5'b10000, 3'd0, 64'd0})
            $display("FAIL reset_single: got %h, expected %h", obs_single(), {5'b10000, 3'd0, 64'd0});
        else passed++;
`ifdef HEADER_INSERTER_STATS_EN
        total++;
        if (pkt_count !== 32'd0 || hdr_stall !== 1'b0)
            $display("FAIL reset_stats: got %h/%b, expected 0/0", pkt_count, hdr_stall);
        else passed++;
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (obs() !== mk(1, 0, 0, 0, 0, 0, '0))
            $display("FAIL reset_release: got %h, expected %h", obs(), mk(1, 0, 0, 0, 0, 0, '0));
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        stim_t st[$];
        logic [OW-1:0] ex[$];
        logic [OW-1:0] got;
        st.push_back(sv(1, {HA, HB}, 0, '0, 0, 0, 1)); ex.push_back(mk(1, 0, 0, 0, 0, 0, '0));
        st.push_back(sv(0, '0, 0, '0, 0, 0, 1));       ex.push_back(mk(0, 0, 1, 1, 0, 0, HA));
        st.push_back(sv(0, '0, 0, '0, 0, 0, 1));       ex.push_back(mk(0, 0, 1, 0, 0, 0, HB));
        st.push_back(sv(0, '0, 1, D0, 0, 0, 1));       ex.push_back(mk(0, 1, 1, 0, 0, 0, D0));
        st.push_back(sv(0, '0, 1, D1, 0, 0, 1));       ex.push_back(mk(0, 1, 1, 0, 0, 0, D1));
        st.push_back(sv(0, '0, 1, D2, 1, 5, 1));       ex.push_back(mk(0, 1, 1, 0, 1, 5, D2));
        st.push_back(sv(0, '0, 0, '0, 0, 0, 1));       ex.push_back(mk(1, 0, 0, 0, 0, 0, '0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            @(negedge clk);
            got = obs();
            total++;
            if (got !== ex[i]) $display("FAIL basic[%0d]: got %h, expected %h", i, got, ex[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        stim_t st[$];
        logic [OW-1:0] ex[$];
        logic [OW-1:0] got;
        st.push_back(sv(1, {HC, HD}, 0, '0, 0, 0, 1)); ex.push_back(mk(1, 0, 0, 0, 0, 0, '0));
        st.push_back(sv(0, '0, 1, D0, 0, 0, 1));       ex.push_back(mk(0, 0, 1, 1, 0, 0, HC));
        for (int k = 0; k < 4; k++) begin
            st.push_back(sv(0, '0, 1, D0, 0, 0, 0));   ex.push_back(mk(0, 0, 1, 0, 0, 0, HD));
        end
        st.push_back(sv(0, '0, 1, D0, 0, 0, 1));       ex.push_back(mk(0, 0, 1, 0, 0, 0, HD));
        st.push_back(sv(0, '0, 1, D0, 0, 0, 1));       ex.push_back(mk(0, 1, 1, 0, 0, 0, D0));
        st.push_back(sv(0, '0, 1, D1, 0, 0, 0));       ex.push_back(mk(0, 0, 1, 0, 0, 0, D1));
        st.push_back(sv(0, '0, 1, D1, 0, 0, 0));       ex.push_back(mk(0, 0, 1, 0, 0, 0, D1));
        st.push_back(sv(0, '0, 1, D1, 0, 0, 1));       ex.push_back(mk(0, 1, 1, 0, 0, 0, D1));
        st.push_back(sv(0, '0, 1, D2, 1, 0, 1));       ex.push_back(mk(0, 1, 1, 0, 1, 0, D2));
        st.push_back(sv(0, '0, 0, '0, 0, 0, 1));       ex.push_back(mk(1, 0, 0, 0, 0, 0, '0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            @(negedge clk);
            got = obs();
            total++;
            if (got !== ex[i]) $display("FAIL backpressure[%0d]: got %h, expected %h", i, got, ex[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_early();
        stim_t st[$];
        logic [OW-1:0] ex[$];
        logic [OW-1:0] got;
        st.push_back(sv(0, '0, 1, D0, 0, 0, 1));       ex.push_back(mk(1, 0, 0, 0, 0, 0, '0));
        st.push_back(sv(1, {HE, HF}, 1, D0, 0, 0, 1)); ex.push_back(mk(1, 0, 0, 0, 0, 0, '0));
        st.push_back(sv(1, {H1, H2}, 1, D0, 0, 0, 1)); ex.push_back(mk(0, 0, 1, 1, 0, 0, HE));
        st.push_back(sv(1, {H1, H2}, 1, D0, 0, 0, 1)); ex.push_back(mk(0, 0, 1, 0, 0, 0, HF));
        st.push_back(sv(1, {H1, H2}, 1, D0, 0, 0, 1)); ex.push_back(mk(0, 1, 1, 0, 0, 0, D0));
        st.push_back(sv(1, {H1, H2}, 1, D1, 1, 3, 1)); ex.push_back(mk(0, 1, 1, 0, 1, 3, D1));
        st.push_back(sv(1, {H1, H2}, 1, D2, 1, 0, 1)); ex.push_back(mk(1, 0, 0, 0, 0, 0, '0));
        st.push_back(sv(0, '0, 1, D2, 1, 0, 1));       ex.push_back(mk(0, 0, 1, 1, 0, 0, H1));
        st.push_back(sv(0, '0, 1, D2, 1, 0, 1));       ex.push_back(mk(0, 0, 1, 0, 0, 0, H2));
        st.push_back(sv(0, '0, 1, D2, 1, 0, 1));       ex.push_back(mk(0, 1, 1, 0, 1, 0, D2));
        st.push_back(sv(0, '0, 0, '0, 0, 0, 1));       ex.push_back(mk(1, 0, 0, 0, 0, 0, '0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            @(negedge clk);
            got = obs();
            total++;
            if (got !== ex[i]) $display("FAIL early[%0d]: got %h, expected %h", i, got, ex[i]);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] pa [4];
        logic [DW-1:0] pb [4];
        logic [DW-1:0] pd [3];
        logic [OW-1:0] got, exp_v;
        for (int k = 0; k < 4; k++) begin
            pa[k] = {32'hA000_0000 + 32'(k), 96'h0};
            pb[k] = {96'h0, 32'hB000_0000 + 32'(k)};
        end
        pd[0] = D0; pd[1] = D1; pd[2] = D2;
        for (int k = 0; k < 3; k++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 0) apply(sv(1, {pa[k], pb[k]}, 1, pd[k], 1, 0, 1));
                else apply(sv(k < 2, {pa[k+1], pb[k+1]}, 1, pd[k], 1, 0, 1));
                case (c)
                    0:       exp_v = mk(1, 0, 0, 0, 0, 0, '0);
                    1:       exp_v = mk(0, 0, 1, 1, 0, 0, pa[k]);
                    2:       exp_v = mk(0, 0, 1, 0, 0, 0, pb[k]);
                    default: exp_v = mk(0, 1, 1, 0, 1, 0, pd[k]);
                endcase
                @(negedge clk);
                got = obs();
                total++;
                if (got !== exp_v)
                    $display("FAIL back_to_back[pkt %0d cyc %0d]: got %h, expected %h", k, c, got, exp_v);
                else passed++;
`ifdef HEADER_INSERTER_STATS_EN
                if (c == 3) begin
                    total++;
                    if (hdr_stall !== (k < 2))
                        $display("FAIL hdr_stall[pkt %0d]: got %b, expected %b", k, hdr_stall, k < 2);
                    else passed++;
                end
`endif
                @(posedge clk); #1;
            end
        end
        apply(sv(0, '0, 0, '0, 0, 0, 1));
        @(negedge clk);
        total++;
        if (obs() !== mk(1, 0, 0, 0, 0, 0, '0))
            $display("FAIL back_to_back_end: got %h, expected %h", obs(), mk(1, 0, 0, 0, 0, 0, '0));
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_config_edge();
        logic [71:0] ex [4];
        logic [71:0] got;
        ex[0] = {5'b10000, 3'd0, 64'd0};
        ex[1] = {5'b00110, 3'd0, 64'h1122_3344_5566_7788};
        ex[2] = {5'b01101, 3'd2, 64'h0000_0000_0000_CAFE};
        ex[3] = {5'b10000, 3'd0, 64'd0};
        for (int i = 0; i < 4; i++) begin
            s_header_valid = (i == 0);
            s_header_data  = (i == 0) ? 64'h1122_3344_5566_7788 : 64'd0;
            s_in_valid     = (i == 1 || i == 2);
            s_in_data      = 64'h0000_0000_0000_CAFE;
            s_in_sop       = s_in_valid;
            s_in_eop       = 1'b1;
            s_in_empty     = 3'd2;
            s_out_ready    = 1'b1;
            @(negedge clk);
            got = obs_single();
            total++;
            if (got !== ex[i]) $display("FAIL config_edge[%0d]: got %h, expected %h", i, got, ex[i]);
            else passed++;
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        stim_t st[$];
        logic [OW-1:0] ex[$];
        logic [OW-1:0] got;
`ifdef HEADER_INSERTER_STATS_EN
        total++;
        if (pkt_count !== 32'd7) $display("FAIL pkt_count_before: got %0d, expected 7", pkt_count);
        else passed++;
`endif
        st.push_back(sv(1, {HA, HB}, 0, '0, 0, 0, 1)); ex.push_back(mk(1, 0, 0, 0, 0, 0, '0));
        st.push_back(sv(0, '0, 1, D0, 0, 0, 1));       ex.push_back(mk(0, 0, 1, 1, 0, 0, HA));
        st.push_back(sv(0, '0, 1, D0, 0, 0, 1));       ex.push_back(mk(0, 0, 1, 0, 0, 0, HB));
        st.push_back(sv(0, '0, 1, D0, 0, 0, 1));       ex.push_back(mk(0, 1, 1, 0, 0, 0, D0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            @(negedge clk);
            got = obs();
            total++;
            if (got !== ex[i]) $display("FAIL reset_mid_pre[%0d]: got %h, expected %h", i, got, ex[i]);
            else passed++;
            @(posedge clk); #1;
        end
        apply(sv(0, '0, 1, D1, 0, 0, 1));
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (obs() !== mk(1, 0, 0, 0, 0, 0, '0))
            $display("FAIL reset_mid_abort: got %h, expected %h", obs(), mk(1, 0, 0, 0, 0, 0, '0));
        else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        apply(sv(0, '0, 0, '0, 0, 0, 1));
`ifdef HEADER_INSERTER_STATS_EN
        @(negedge clk);
        total++;
        if (pkt_count !== 32'd0) $display("FAIL pkt_count_after_reset: got %0d, expected 0", pkt_count);
        else passed++;
        @(posedge clk); #1;
`endif
        st.delete(); ex.delete();
        st.push_back(sv(1, {HC, HD}, 0, '0, 0, 0, 1)); ex.push_back(mk(1, 0, 0, 0, 0, 0, '0));
        st.push_back(sv(0, '0, 1, D3, 1, 7, 1));       ex.push_back(mk(0, 0, 1, 1, 0, 0, HC));
        st.push_back(sv(0, '0, 1, D3, 1, 7, 1));       ex.push_back(mk(0, 0, 1, 0, 0, 0, HD));
        st.push_back(sv(0, '0, 1, D3, 1, 7, 1));       ex.push_back(mk(0, 1, 1, 0, 1, 7, D3));
        st.push_back(sv(0, '0, 0, '0, 0, 0, 1));       ex.push_back(mk(1, 0, 0, 0, 0, 0, '0));
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            @(negedge clk);
            got = obs();
            total++;
            if (got !== ex[i]) $display("FAIL reset_mid_post[%0d]: got %h, expected %h", i, got, ex[i]);
            else passed++;
            @(posedge clk); #1;
        end
`ifdef HEADER_INSERTER_STATS_EN
        total++;
        if (pkt_count !== 32'd1) $display("FAIL pkt_count_final: got %0d, expected 1", pkt_count);
        else passed++;
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_early();
        test_back_to_back();
        test_config_edge();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/header_inserter.md
Name: header_inserter

Overview:
- Prepends a fixed-size header to every Avalon-ST packet; the transmit-side counterpart of the header stripping stage.
- Captures one header per packet through a valid/ready side port.
- Emits the header as HEADER_SIZE/DATA_WIDTH leading words, MSB word first, then passes the payload through unchanged.
- Sits in front of the link or framer.

Parameters:
- DATA_WIDTH, 128, stream word width in bits.
- HEADER_SIZE, 256, header width in bits. Must be an integer multiple of DATA_WIDTH and at least DATA_WIDTH. Violations are flagged by an elaboration-time assertion.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- header_data  input  HEADER_SIZE  header for the next packet.
- header_valid  input  1  header_data valid.
- header_ready  output  1  header accepted when header_valid & header_ready.
- data_in  avalon_st_if.slave  DATA_WIDTH  payload stream (data, valid, ready, sop, eop, empty).
- data_out  avalon_st_if.master  DATA_WIDTH  header + payload stream.

Behaviour:
- Derived constant: HEADER_WORDS = HEADER_SIZE/DATA_WIDTH. The word counter is $clog2(HEADER_WORDS)+1 bits.
- States are IDLE, HEADER and DATA. Reset state is IDLE.
- Reset values:
  - header_ready=1 (combinational from IDLE).
  - data_out.valid=0, data_out.sop=0, data_out.eop=0, data_out.empty=0.
  - Header register and counter cleared.
- IDLE:
  - header_ready=1, data_in.ready=0, data_out.valid=0.
  - On header_valid, latch header_data into the internal register, clear the counter, and go to HEADER.
- HEADER:
  - data_out.valid=1.
  - data_out.data = header word at counter index. Word i = hdr[HEADER_SIZE-1-i*DATA_WIDTH -: DATA_WIDTH].
  - data_out.sop=1 only for word 0. eop=0, empty=0.
  - On data_out.ready, increment the counter. When the last word (index HEADER_WORDS-1) is accepted, go to DATA.
  - data_in.ready=0. header_ready=0.
- DATA:
  - data_out.valid=data_in.valid and data_in.ready=data_out.ready, both combinational.
  - data, eop and empty pass straight through. data_out.sop is forced to 0.
  - data_in.sop is ignored.
  - On an accepted beat with data_in.eop, go to IDLE.
- Latency:
  - Header accepted in cycle N; header word 0 is presented in cycle N+1.
  - Payload passes through with zero cycles of latency.
  - Exactly one idle cycle separates packets (the IDLE cycle that accepts the next header).
- Backpressure:
  - In HEADER, data_out fields stay stable while valid & !ready, because they come from the register.
  - In DATA, stability is inherited from the upstream Avalon-ST guarantee.
- Header register changes only on header accept. A new header_valid during HEADER or DATA is stalled, not dropped.
- data_in.valid asserted during IDLE or HEADER is stalled (ready=0); payload is never lost or reordered.
- HEADER_WORDS=1: the HEADER state lasts one accepted beat, carrying both sop and the whole header.
- Single-beat payload (eop on the first data beat) returns to IDLE after that beat.
- Reset mid-packet: return immediately to IDLE with data_out.valid=0. The partially sent packet is abandoned; upstream must also be reset.

Optional Feature:
- Macro: HEADER_INSERTER_STATS_EN.
- When defined:
  - Adds output pkt_count [31:0], which increments on each accepted data_out beat with eop and wraps 0xFFFFFFFF -> 0.
  - Adds output hdr_stall, which is 1 when the block is in DATA with header_valid=1 (next header waiting).
  - Both reset to 0.
- When undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Basic packet:
  - Stimulus: header 0xAAAA...(128b)_BBBB...(128b), then 3 payload beats D0..D2 with eop on D2, empty=5.
  - Required: out = AAAA(sop) , BBBB, D0, D1, D2(eop, empty=5); sop on exactly one beat.
- Output backpressure:
  - Stimulus: data_out.ready=0 for 4 cycles during header word 1, and for 2 cycles during D1.
  - Required: fields are held stable, no duplicates or drops, data_in.ready=0 while stalled.
- Early payload and header:
  - Stimulus: payload valid before header_valid; a second header offered mid-packet.
  - Required: payload is held until the header words are sent; the second header is accepted only in the IDLE cycle after eop.
- Back-to-back packets:
  - Stimulus: 1-beat payload packets with headers always valid.
  - Required: repeating period of 4 cycles (IDLE + 2 header + 1 data); headers stay in order.
- Configuration edge:
  - Stimulus: HEADER_SIZE=DATA_WIDTH=64.
  - Required: a single header beat carrying sop, followed by the payload.
- Reset mid-operation:
  - Stimulus: assert rst during DATA beat 1.
  - Required: data_out.valid=0 in the same cycle, header_ready=1; the next packet is correct. With HEADER_INSERTER_STATS_EN, pkt_count=0 after reset.
